decode_cycle: RTL and testbench
===============================

# decode_cycle

Decode stage of the five-stage RISC-V (RV32I subset) pipeline, directly downstream of the fetch stage. Consumes InstrD/PCD/PCPlus4D from the IF/ID register, decodes control, reads/writes the 32×32 register file, sign-extends immediates, and registers everything into the ID/EX pipeline register. Accepts write-back from the W stage and a flush from the hazard unit.

## Interface
- XLEN, 32, datapath width
- NREGS, 32, register-file depth (x0 hard-wired zero)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- InstrD, PCD, PCPlus4D  in  32 each  from IF/ID register
- RegWriteW  in  1  write-back enable
- RDW  in  5  write-back destination
- ResultW  in  32  write-back data
- FlushE  in  1  load bubble into ID/EX
- Rs1D, Rs2D  out  5 each  combinational InstrD[19:15]/[24:20], to hazard unit
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered controls
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered data
- RdE, Rs1E, Rs2E  out  5 each  registered register indices

## Operation
- Main decoder on InstrD[6:0]: lw 0000011, sw 0100011, R 0110011, beq 1100011, I-ALU 0010011, jal 1101111; any other opcode -> all controls 0, ImmExt 0.
- ALUOp: 00 lw/sw/jal (add), 01 beq (sub), 10 R/I-ALU; funct3 000 -> sub only when op[5]&funct7[5], else add; 010 slt; 110 or; 111 and; other funct3 -> add.
- ImmSrc: 00 I {20×instr[31],instr[31:20]}; 01 S; 10 B (bit0=0); 11 J (bit0=0). All sign-extended from instr[31].
- Register file: reads combinational on Rs1D/Rs2D; index 0 always reads 0. Write at rising clk when RegWriteW && RDW!=0; writes to x0 discarded.
- ID/EX register: captures all decoded controls, RD1/RD2, ImmExt, PCD, PCPlus4D, rd=InstrD[11:7], Rs1D, Rs2D every edge.
- FlushE=1 at edge: every E output loads 0 (bubble; RegWriteE=MemWriteE=BranchE=JumpE=0). Register-file write in the same edge still performed.
- Priority at an edge: reset > FlushE > normal load.

## Timing
- Latency: decode inputs at edge N appear on E outputs after edge N; no stall input (StallD lives in IF/ID).
- Rs1D/Rs2D: zero-cycle combinational.
- Reset (rst=0 at edge): all E outputs 0, all registers x1–x31 cleared to 0; reset held mid-stream drops the in-flight instruction, W write in that edge discarded.
- Simultaneous W write and D read of same non-zero register: see Configuration.

## Configuration
- RF_WRITE_THROUGH_EN defined: read port returns ResultW when RegWriteW && RDW==rs && rs!=0 (internal bypass), so RD1E/RD2E capture the new value in the write edge.
- Undefined: read returns pre-write contents; hazard unit must cover the W->D case by stall. All other behaviour identical.

## Structure
- Shared package riscv_pkg: opcode constants, ALUControl encodings, ImmSrc and ResultSrc encodings, XLEN.
- One sub-module: register_file (storage, x0 rule, reset, optional write-through). Decoder, extender and ID/EX register inline in decode_cycle.

## Test plan
- Reset: rst=0 one edge -> all E outputs 0; after release, reading any register gives 0.
- InstrD=0x00700293 (addi x5,x0,7) -> next edge RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=7, RdE=5, Rs1E=0, ResultSrcE=00.
- Write x5=0xDEADBEEF via W, then InstrD=0x00528333 (add x6,x5,x5) -> RD1E=RD2E=0xDEADBEEF, RdE=6, ALUControlE=000; repeat with write in same cycle: with macro 0xDEADBEEF, without macro old value.
- InstrD=0xFE208CE3 (beq x1,x2,-8) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8, RegWriteE=0.
- sw in D with FlushE=1 -> all E outputs 0, MemWriteE=0; concurrent W write to x7 still visible next cycle.
- RegWriteW=1, RDW=0, ResultW=0x1234 -> subsequent read of x0 returns 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants, ID/EX register layout and immediate extender.
// Ports: none (package). Imported by register_file and decode_cycle.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } id_ex_t;

    // B and J immediates carry an implicit zero LSB; all formats sign-extend from instr[31].
    function automatic logic [XLEN-1:0] imm_extend(input logic [31:7] instr, input logic [1:0] src);
        case (src)
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// register_file: 32x32 register file, x0 hard-wired to zero, synchronous active-low clear.
// Ports: clk, rst (active-low sync), we/wa/wd write port, ra1/ra2 -> rd1/rd2 combinational reads.
// Option: RF_WRITE_THROUGH_EN bypasses same-edge write data onto a matching read port.
module register_file
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_comb begin
        regs_d = regs_q;
        if (we && wa != 5'd0) regs_d[wa] = wd;
    end

    always_ff @(posedge clk) begin
        if (!rst) regs_q <= '{default: '0};
        else      regs_q <= regs_d;
    end

    always_comb begin
        rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
        rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];
`ifdef RF_WRITE_THROUGH_EN
        if (we && ra1 != 5'd0 && wa == ra1) rd1 = wd;
        if (we && ra2 != 5'd0 && wa == ra2) rd2 = wd;
`endif
    end

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage - control decode, register read/write-back, immediate
// extension and the ID/EX pipeline register.
// Ports: clk, rst (active-low sync); InstrD/PCD/PCPlus4D from IF/ID; RegWriteW/RDW/ResultW
// write-back; FlushE bubble; Rs1D/Rs2D combinational to hazard unit; *E registered outputs.
// Option: RF_WRITE_THROUGH_EN (passed to register_file) enables W->D internal bypass.
module decode_cycle
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RdE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E
);

    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            reg_write, mem_write, jump, branch, alu_src, imm_en;
    logic [1:0]      result_src, imm_src, alu_op;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1, rd2;
    id_ex_t          ex_d, ex_q;

    assign op     = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign Rs1D   = InstrD[19:15];
    assign Rs2D   = InstrD[24:20];

    register_file u_rf (
        .clk (clk),
        .rst (rst),
        .we  (RegWriteW),
        .wa  (RDW),
        .wd  (ResultW),
        .ra1 (Rs1D),
        .ra2 (Rs2D),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // Unrecognised opcodes decode to an all-zero control word and a zero immediate.
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        result_src = RES_ALU;
        imm_src    = IMM_I;
        alu_op     = 2'b00;
        imm_en     = 1'b1;
        case (op)
            OP_LW:   begin reg_write = 1'b1; alu_src = 1'b1; result_src = RES_MEM; end
            OP_SW:   begin mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_S; end
            OP_R:    begin reg_write = 1'b1; alu_op = 2'b10; end
            OP_BEQ:  begin branch = 1'b1; imm_src = IMM_B; alu_op = 2'b01; end
            OP_IALU: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
            OP_JAL:  begin reg_write = 1'b1; jump = 1'b1; imm_src = IMM_J; result_src = RES_PC4; end
            default: imm_en = 1'b0;
        endcase
    end

    // Subtract only for R-type with funct7[5]; addi with imm bit 10 set must stay add.
    always_comb begin
        alu_control = ALU_ADD;
        if (alu_op == 2'b01) alu_control = ALU_SUB;
        else if (alu_op == 2'b10)
            case (funct3)
                3'b000:  alu_control = (op[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: alu_control = ALU_ADD;
            endcase
    end

    always_comb begin
        ex_d = '{
            reg_write:   reg_write,
            mem_write:   mem_write,
            jump:        jump,
            branch:      branch,
            alu_src:     alu_src,
            result_src:  result_src,
            alu_control: alu_control,
            rd1:         rd1,
            rd2:         rd2,
            imm_ext:     imm_en ? imm_extend(InstrD[31:7], imm_src) : '0,
            pc:          PCD,
            pc_plus4:    PCPlus4D,
            rd:          InstrD[11:7],
            rs1:         Rs1D,
            rs2:         Rs2D
        };
        if (FlushE) ex_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) ex_q <= '0;
        else      ex_q <= ex_d;
    end

    assign RegWriteE   = ex_q.reg_write;
    assign MemWriteE   = ex_q.mem_write;
    assign JumpE       = ex_q.jump;
    assign BranchE     = ex_q.branch;
    assign ALUSrcE     = ex_q.alu_src;
    assign ResultSrcE  = ex_q.result_src;
    assign ALUControlE = ex_q.alu_control;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign ImmExtE     = ex_q.imm_ext;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign RdE         = ex_q.rd;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed self-checking bench for decode_cycle.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [9:0]  ctrl_e;
    int          tests = 0;
    int          fails = 0;

    // {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
    assign ctrl_e = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RegWriteW   (RegWriteW),
        .RDW         (RDW),
        .ResultW     (ResultW),
        .FlushE      (FlushE),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .RdE         (RdE),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; InstrD = 32'h00700293; PCD = 32'h100; PCPlus4D = 32'h104;
        RegWriteW = 1'b0; RDW = 5'd0; ResultW = '0; FlushE = 1'b0;
        step();
        tests++; if (ctrl_e !== 10'd0) begin fails++; $display("FAIL reset_ctrl got %b exp 0", ctrl_e); end
        tests++; if ({RD1E, RD2E, ImmExtE, PCE, PCPlus4E} !== 160'd0) begin fails++; $display("FAIL reset_data got %h %h %h %h %h exp 0", RD1E, RD2E, ImmExtE, PCE, PCPlus4E); end
        tests++; if ({RdE, Rs1E, Rs2E} !== 15'd0) begin fails++; $display("FAIL reset_idx got %h exp 0", {RdE, Rs1E, Rs2E}); end
        rst = 1'b1; InstrD = 32'h00528333;
        step();
        tests++; if ({RD1E, RD2E} !== 64'd0) begin fails++; $display("FAIL reset_x5_read got %h %h exp 0", RD1E, RD2E); end
        InstrD = 32'hFE208CE3;
        #1;
        tests++; if ({Rs1D, Rs2D} !== {5'd1, 5'd2}) begin fails++; $display("FAIL rs_comb got %0d %0d exp 1 2", Rs1D, Rs2D); end
    endtask

    task automatic test_addi;
        InstrD = 32'h00700293; PCD = 32'h1000; PCPlus4D = 32'h1004;
        step();
        tests++; if (ctrl_e !== 10'b1000100000) begin fails++; $display("FAIL addi_ctrl got %b exp 1000100000", ctrl_e); end
        tests++; if (ImmExtE !== 32'd7) begin fails++; $display("FAIL addi_imm got %h exp 7", ImmExtE); end
        tests++; if ({RdE, Rs1E} !== {5'd5, 5'd0}) begin fails++; $display("FAIL addi_idx got %0d %0d exp 5 0", RdE, Rs1E); end
        tests++; if ({PCE, PCPlus4E} !== {32'h1000, 32'h1004}) begin fails++; $display("FAIL addi_pc got %h %h exp 1000 1004", PCE, PCPlus4E); end
        InstrD = 32'h40000093;
        step();
        tests++; if (ctrl_e !== 10'b1000100000 || ImmExtE !== 32'h400) begin fails++; $display("FAIL addi_f7_still_add got %b %h exp 1000100000 400", ctrl_e, ImmExtE); end
    endtask

    task automatic test_alu_decode;
        InstrD = 32'h0020E1B3;
        step();
        tests++; if (ctrl_e !== 10'b1000000011) begin fails++; $display("FAIL or_ctrl got %b exp 1000000011", ctrl_e); end
        InstrD = 32'h402081B3;
        step();
        tests++; if (ctrl_e !== 10'b1000000001) begin fails++; $display("FAIL sub_ctrl got %b exp 1000000001", ctrl_e); end
        InstrD = 32'h0050A193;
        step();
        tests++; if (ctrl_e !== 10'b1000100101 || ImmExtE !== 32'd5) begin fails++; $display("FAIL slti got %b %h exp 1000100101 5", ctrl_e, ImmExtE); end
    endtask

    task automatic test_branch_jump_load;
        InstrD = 32'hFE208CE3;
        step();
        tests++; if (ctrl_e !== 10'b0001000001) begin fails++; $display("FAIL beq_ctrl got %b exp 0001000001", ctrl_e); end
        tests++; if (ImmExtE !== 32'hFFFFFFF8) begin fails++; $display("FAIL beq_imm got %h exp fffffff8", ImmExtE); end
        InstrD = 32'hFFDFF0EF;
        step();
        tests++; if (ctrl_e !== 10'b1010010000 || ImmExtE !== 32'hFFFFFFFC) begin fails++; $display("FAIL jal got %b %h exp 1010010000 fffffffc", ctrl_e, ImmExtE); end
        InstrD = 32'hFFC12203;
        step();
        tests++; if (ctrl_e !== 10'b1000101000 || ImmExtE !== 32'hFFFFFFFC) begin fails++; $display("FAIL lw got %b %h exp 1000101000 fffffffc", ctrl_e, ImmExtE); end
        InstrD = 32'hFFFFFFFF;
        step();
        tests++; if (ctrl_e !== 10'd0 || ImmExtE !== 32'd0 || RdE !== 5'd31) begin fails++; $display("FAIL unknown_op got %b %h %0d exp 0 0 31", ctrl_e, ImmExtE, RdE); end
    endtask

    task automatic test_regfile;
        logic [31:0] exp_same;
        InstrD = 32'h0; RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hDEADBEEF;
        step();
        RegWriteW = 1'b0; InstrD = 32'h00528333;
        step();
        tests++; if ({RD1E, RD2E} !== {2{32'hDEADBEEF}}) begin fails++; $display("FAIL rf_read got %h %h exp deadbeef", RD1E, RD2E); end
        tests++; if (RdE !== 5'd6 || ctrl_e !== 10'b1000000000) begin fails++; $display("FAIL add_decode got %0d %b exp 6 1000000000", RdE, ctrl_e); end
        RegWriteW = 1'b1; ResultW = 32'hCAFEF00D;
        step();
`ifdef RF_WRITE_THROUGH_EN
        exp_same = 32'hCAFEF00D;
`else
        exp_same = 32'hDEADBEEF;
`endif
        tests++; if ({RD1E, RD2E} !== {2{exp_same}}) begin fails++; $display("FAIL same_edge_read got %h %h exp %h", RD1E, RD2E, exp_same); end
        RegWriteW = 1'b0;
        step();
        tests++; if (RD1E !== 32'hCAFEF00D) begin fails++; $display("FAIL after_write got %h exp cafef00d", RD1E); end
    endtask

    task automatic test_flush;
        InstrD = 32'h00702223; PCD = 32'h200; PCPlus4D = 32'h204;
        FlushE = 1'b1; RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'hA5A5A5A5;
        step();
        tests++; if (ctrl_e !== 10'd0 || {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, Rs1E, Rs2E} !== 175'd0) begin fails++; $display("FAIL flush got %b %h %h %h %h exp 0", ctrl_e, ImmExtE, PCE, PCPlus4E, RD2E); end
        FlushE = 1'b0; RegWriteW = 1'b0; InstrD = 32'h00038093;
        step();
        tests++; if (RD1E !== 32'hA5A5A5A5 || RdE !== 5'd1) begin fails++; $display("FAIL flush_write_kept got %h %0d exp a5a5a5a5 1", RD1E, RdE); end
        InstrD = 32'h00702223;
        step();
        tests++; if (ctrl_e !== 10'b0100100000 || ImmExtE !== 32'd4 || RD2E !== 32'hA5A5A5A5) begin fails++; $display("FAIL sw got %b %h %h exp 0100100000 4 a5a5a5a5", ctrl_e, ImmExtE, RD2E); end
    endtask

    task automatic test_x0;
        InstrD = 32'h00000333; RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h1234;
        step();
        tests++; if ({RD1E, RD2E} !== 64'd0) begin fails++; $display("FAIL x0_same_edge got %h %h exp 0", RD1E, RD2E); end
        RegWriteW = 1'b0;
        step();
        tests++; if ({RD1E, RD2E} !== 64'd0) begin fails++; $display("FAIL x0_read got %h %h exp 0", RD1E, RD2E); end
    endtask

    task automatic test_reset_midstream;
        InstrD = 32'h0; RegWriteW = 1'b1; RDW = 5'd9; ResultW = 32'h55;
        step();
        RegWriteW = 1'b0; InstrD = 32'h00948333;
        step();
        tests++; if (RD1E !== 32'h55) begin fails++; $display("FAIL pre_reset_x9 got %h exp 55", RD1E); end
        rst = 1'b0; RegWriteW = 1'b1; RDW = 5'd10; ResultW = 32'h77;
        step();
        tests++; if (ctrl_e !== 10'd0 || RD1E !== 32'd0 || RdE !== 5'd0) begin fails++; $display("FAIL midreset_drop got %b %h %0d exp 0", ctrl_e, RD1E, RdE); end
        rst = 1'b1; RegWriteW = 1'b0; InstrD = 32'h00A48333;
        step();
        tests++; if ({RD1E, RD2E} !== 64'd0) begin fails++; $display("FAIL midreset_clear got %h %h exp 0", RD1E, RD2E); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu_decode();
        test_branch_jump_load();
        test_regfile();
        test_flush();
        test_x0();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
